// File: rtl/uk_light_pkg.sv
// Shared state encoding and sizing helpers for the multi-approach UK light controller.
package uk_light_pkg;

   localparam int STATE_W = 6;

   typedef enum logic [STATE_W-1:0] {
      ST_OFF    = 6'b000001,
      ST_RED    = 6'b000010,
      ST_RDYLW  = 6'b000100,
      ST_GREEN  = 6'b001000,
      ST_YELLOW = 6'b010000,
      ST_WALK   = 6'b100000
   } state_t;

   function automatic int max_dwell(input int a, input int b, input int c,
                                    input int d, input int e);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      return m;
   endfunction

   // The timer holds dwell-1, so $clog2(max) bits suffice; keep at least one bit.
   function automatic int cnt_width(input int max_cyc);
      return (max_cyc > 1) ? $clog2(max_cyc) : 1;
   endfunction

endpackage

// File: rtl/uk_light_junction_if.sv
// Control/lamp bundle between junction logic, the controller and the lamp drivers.
// Pedestrian signals exist only when UK_LIGHT_PED_EN is defined.
interface uk_light_junction_if #(
   parameter int N_WAY = 4
) ();
   localparam int AW = $clog2(N_WAY);

   // No valid/ready pair: enable is a level sampled every posedge, and the
   // lamp/state outputs are Moore levels valid for the whole cycle.
   logic             enable;
   logic [N_WAY-1:0] red;
   logic [N_WAY-1:0] ylwred;
   logic [N_WAY-1:0] green;
   logic [N_WAY-1:0] yellow;
   logic [5:0]       state_out;
   logic [AW-1:0]    active_way;
`ifdef UK_LIGHT_PED_EN
   logic             ped_req;
   logic             ped_walk;
`endif

   modport master (
      input  enable,
`ifdef UK_LIGHT_PED_EN
      input  ped_req,
      output ped_walk,
`endif
      output red, ylwred, green, yellow, state_out, active_way
   );

   modport slave (
      output enable,
`ifdef UK_LIGHT_PED_EN
      output ped_req,
      input  ped_walk,
`endif
      input  red, ylwred, green, yellow, state_out, active_way
   );

endinterface

// File: rtl/uk_light_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module uk_light_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/uk_light_junction.sv
// Round-robin N_WAY UK traffic-light controller with per-phase dwell timing.
// Optional pedestrian WALK phase is built when UK_LIGHT_PED_EN is defined.
module uk_light_junction
   import uk_light_pkg::*;
#(
   parameter int N_WAY      = 4,
   parameter int ALLRED_CYC = 2,
   parameter int RA_CYC     = 2,
   parameter int GREEN_CYC  = 8,
   parameter int AMBER_CYC  = 3,
   parameter int WALK_CYC   = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   uk_light_junction_if.master bus
);

   localparam int AW = $clog2(N_WAY);
   localparam int TW = cnt_width(max_dwell(ALLRED_CYC, RA_CYC, GREEN_CYC,
                                           AMBER_CYC, WALK_CYC));
   localparam logic [AW-1:0] LAST_WAY = AW'(N_WAY - 1);

   state_t        state;
   state_t        nxt;
   logic [AW-1:0] way;
   logic          done;
   logic          load;
   logic [TW-1:0] load_val;
   logic          walk_ok;
   logic [N_WAY-1:0] sel;

   function automatic logic [TW-1:0] dwell_m1(input state_t s);
      case (s)
         ST_RED:    return TW'(ALLRED_CYC - 1);
         ST_RDYLW:  return TW'(RA_CYC - 1);
         ST_GREEN:  return TW'(GREEN_CYC - 1);
         ST_YELLOW: return TW'(AMBER_CYC - 1);
         ST_WALK:   return TW'(WALK_CYC - 1);
         default:   return '0;
      endcase
   endfunction

`ifdef UK_LIGHT_PED_EN
   logic ped_pend;
   assign walk_ok = ped_pend;
`else
   assign walk_ok = 1'b0;
`endif

   always_comb begin
      nxt = state;
      case (state)
         ST_OFF:    if (bus.enable) nxt = ST_RED;
         ST_RED:    if (!bus.enable) nxt = ST_OFF;
                    else if (done) nxt = ST_RDYLW;
         ST_RDYLW:  if (!bus.enable) nxt = ST_OFF;
                    else if (done) nxt = ST_GREEN;
         // Green is cut short on disable but the amber always runs in full.
         ST_GREEN:  if (!bus.enable || done) nxt = ST_YELLOW;
         ST_YELLOW: if (done) begin
                       if (!bus.enable) nxt = ST_OFF;
                       else if (walk_ok) nxt = ST_WALK;
                       else nxt = ST_RED;
                    end
         ST_WALK:   if (done) nxt = bus.enable ? ST_RED : ST_OFF;
         default:   nxt = ST_OFF;
      endcase
   end

   // Every state change reloads the dwell; there are no self-transitions.
   assign load     = (nxt != state);
   assign load_val = dwell_m1(nxt);

   uk_light_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .done     (done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_OFF;
         way   <= '0;
`ifdef UK_LIGHT_PED_EN
         ped_pend <= 1'b0;
`endif
      end else begin
         state <= nxt;
         if (state == ST_YELLOW && done) begin
            way <= (way == LAST_WAY) ? '0 : way + AW'(1);
         end
`ifdef UK_LIGHT_PED_EN
         // A request coinciding with WALK entry is kept for the next amber.
         ped_pend <= (ped_pend && !(nxt == ST_WALK && state != ST_WALK)) || bus.ped_req;
`endif
      end
   end

   always_comb begin
      sel      = '0;
      sel[way] = 1'b1;
   end

   always_comb begin
      bus.red    = '1;
      bus.ylwred = '0;
      bus.green  = '0;
      bus.yellow = '0;
      case (state)
         ST_RDYLW:  begin bus.ylwred = sel; bus.red = ~sel; end
         ST_GREEN:  begin bus.green  = sel; bus.red = ~sel; end
         ST_YELLOW: begin bus.yellow = sel; bus.red = ~sel; end
         default:   ;
      endcase
   end

   assign bus.active_way = way;

`ifdef UK_LIGHT_PED_EN
   assign bus.state_out = state;
   assign bus.ped_walk  = (state == ST_WALK);
`else
   assign bus.state_out = {1'b0, state[4:0]};
`endif

endmodule

// File: tb/tb_uk_light_junction.sv
// Directed bench for uk_light_junction (N_WAY=3, dwells 2/2/5/3, walk 6).
// The pedestrian scenario is included when UK_LIGHT_PED_EN is defined.
module tb_uk_light_junction;

   localparam int NW = 3;
   localparam logic [5:0] S_OFF    = 6'b000001;
   localparam logic [5:0] S_RED    = 6'b000010;
   localparam logic [5:0] S_RDYLW  = 6'b000100;
   localparam logic [5:0] S_GREEN  = 6'b001000;
   localparam logic [5:0] S_YELLOW = 6'b010000;
   localparam logic [5:0] S_WALK   = 6'b100000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   tests_run    = 0;
   int   tests_failed = 0;

   uk_light_junction_if #(.N_WAY(NW)) bus ();

   uk_light_junction #(
      .N_WAY(NW), .ALLRED_CYC(2), .RA_CYC(2), .GREEN_CYC(5),
      .AMBER_CYC(3), .WALK_CYC(6)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected lamps follow directly from the state and the released approach.
   task automatic check(input string tag, input logic [5:0] st, input int way);
      logic [NW-1:0] sel, er, ery, eg, ey;
      logic          ew;
      sel = '0;
      sel[way] = 1'b1;
      er = '1; ery = '0; eg = '0; ey = '0; ew = 1'b0;
      case (st)
         S_RDYLW:  begin ery = sel; er = ~sel; end
         S_GREEN:  begin eg  = sel; er = ~sel; end
         S_YELLOW: begin ey  = sel; er = ~sel; end
         S_WALK:   ew = 1'b1;
         default:  ;
      endcase
      cmp({tag, "/state"},  32'(bus.state_out),  32'(st));
      cmp({tag, "/way"},    32'(bus.active_way), 32'(way));
      cmp({tag, "/red"},    32'(bus.red),        32'(er));
      cmp({tag, "/ylwred"}, 32'(bus.ylwred),     32'(ery));
      cmp({tag, "/green"},  32'(bus.green),      32'(eg));
      cmp({tag, "/yellow"}, 32'(bus.yellow),     32'(ey));
      cmp({tag, "/green_multi"}, 32'($countones(bus.green) <= 1), 32'(1));
      for (int i = 0; i < NW; i++) begin
         cmp({tag, "/one_lamp"},
             32'(int'(bus.red[i]) + int'(bus.ylwred[i]) + int'(bus.green[i]) + int'(bus.yellow[i])),
             32'(1));
      end
`ifdef UK_LIGHT_PED_EN
      cmp({tag, "/ped_walk"}, 32'(bus.ped_walk), 32'(ew));
`else
      if (ew) cmp({tag, "/walk_unreachable"}, 32'(bus.state_out[5]), 32'(1));
`endif
   endtask

   task automatic run_phase(input string tag, input logic [5:0] st, input int way, input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         check(tag, st, way);
      end
   endtask

   task automatic run_approach(input int way);
      run_phase("red",    S_RED,    way, 2);
      run_phase("rdylw",  S_RDYLW,  way, 2);
      run_phase("green",  S_GREEN,  way, 5);
      run_phase("yellow", S_YELLOW, way, 3);
   endtask

   initial begin
      bus.enable = 1'b0;
`ifdef UK_LIGHT_PED_EN
      bus.ped_req = 1'b0;
`endif
      // Reset held with enable low
      rst_n = 1'b0;
      repeat (2) tick();
      check("reset", S_OFF, 0);
      rst_n = 1'b1;
      run_phase("off_idle", S_OFF, 0, 2);

      // Three full approaches, then the wrap back to approach 0
      bus.enable = 1'b1;
      run_approach(0);
      run_approach(1);
      run_approach(2);
      run_phase("wrap_red",   S_RED,   0, 2);
      run_phase("wrap_rdylw", S_RDYLW, 0, 2);
      run_phase("wrap_green", S_GREEN, 0, 2);

      // Disable in the second green cycle: amber in full, then OFF, way advanced
      bus.enable = 1'b0;
      run_phase("dis_yellow", S_YELLOW, 0, 3);
      run_phase("dis_off",    S_OFF,    1, 2);
      bus.enable = 1'b1;
      run_phase("reen_red",   S_RED,    1, 2);
      run_phase("reen_rdylw", S_RDYLW,  1, 2);
      run_phase("reen_green", S_GREEN,  1, 1);

      // Asynchronous reset mid-green, checked before any clock edge
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst", S_OFF, 0);
      bus.enable = 1'b0;
      tick();
      rst_n = 1'b1;
      run_phase("post_rst", S_OFF, 0, 1);

      // Disable while in RED drops straight to OFF
      bus.enable = 1'b1;
      run_phase("red_dis_a", S_RED, 0, 1);
      bus.enable = 1'b0;
      run_phase("red_dis_off", S_OFF, 0, 1);

`ifdef UK_LIGHT_PED_EN
      // Pedestrian request during green inserts WALK before the next RED
      bus.enable = 1'b1;
      run_phase("ped_red",   S_RED,   0, 2);
      run_phase("ped_rdylw", S_RDYLW, 0, 2);
      run_phase("ped_green", S_GREEN, 0, 1);
      bus.ped_req = 1'b1;
      run_phase("ped_green_req", S_GREEN, 0, 1);
      bus.ped_req = 1'b0;
      run_phase("ped_green_rest", S_GREEN,  0, 3);
      run_phase("ped_yellow",     S_YELLOW, 0, 3);
      run_phase("ped_walk",       S_WALK,   1, 6);
      run_phase("ped_after_red",  S_RED,    1, 2);
      run_phase("ped_no_repeat",  S_RDYLW,  1, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/uk_light_junction.md
# uk_light_junction

Parametrised multi-approach UK traffic-light controller, the successor to the single-head `uk_light` FSM. It sequences `N_WAY` approaches round-robin through RED → RED+AMBER → GREEN → AMBER, with exactly one approach released at a time. Per-phase dwell times are parameters rather than fixed single cycles. It sits between the junction enable/control logic and the lamp drivers.

## Interface
- `N_WAY`, 4: number of approaches, minimum 2.
- `ALLRED_CYC`, 2: all-red clearance dwell in cycles, minimum 1.
- `RA_CYC`, 2: red+amber dwell in cycles, minimum 1.
- `GREEN_CYC`, 8: green dwell in cycles, minimum 1.
- `AMBER_CYC`, 3: amber dwell in cycles, minimum 1.
- `WALK_CYC`, 6: pedestrian walk dwell in cycles, minimum 1. Used only with `UK_LIGHT_PED_EN`.
- `clk`  in  1  single system clock; all state changes on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request, sampled at posedge.
- `red`  out  N_WAY  red lamp per approach.
- `ylwred`  out  N_WAY  red+amber lamp per approach.
- `green`  out  N_WAY  green lamp per approach.
- `yellow`  out  N_WAY  amber lamp per approach.
- `state_out`  out  6  one-hot current state.
- `active_way`  out  $clog2(N_WAY)  index of the approach currently being sequenced.
- `ped_req`  in  1  pedestrian request pulse. Present only with `UK_LIGHT_PED_EN`.
- `ped_walk`  out  1  walk indicator. Present only with `UK_LIGHT_PED_EN`.

## Operation
- States (one-hot): OFF=000001, RED=000010, RDYLW=000100, GREEN=001000, YELLOW=010000, WALK=100000.
- OFF: every `red` bit is 1; all other lamps are 0.
- RED: all approaches show red (clearance).
- RDYLW: `ylwred[active_way]`=1; all other approaches show red.
- GREEN: `green[active_way]`=1; all other approaches show red.
- YELLOW: `yellow[active_way]`=1; all other approaches show red.
- WALK: all approaches show red and `ped_walk`=1.
- Exactly one lamp bit is set per approach in every state.
- Normal flow: OFF →(enable)→ RED →(ALLRED_CYC)→ RDYLW →(RA_CYC)→ GREEN →(GREEN_CYC)→ YELLOW →(AMBER_CYC)→ RED.
- On YELLOW exit, `active_way` increments modulo N_WAY; N_WAY-1 wraps to 0.
- Disabling, with `enable`=0 sampled:
  - in RED or RDYLW: go to OFF next cycle.
  - in GREEN: go to YELLOW immediately, run the full amber dwell, then OFF.
  - in YELLOW or WALK: complete the dwell, then OFF.
  - `active_way` still advances on YELLOW exit.
- Re-enable from OFF always enters RED with a fresh dwell. `active_way` is retained.
- Reset, mid-operation or otherwise: state=OFF, `active_way`=0, timer cleared, pending pedestrian request cleared. Effect is immediate and asynchronous.

## Timing
- All outputs are Moore outputs, decoded from registered state. They change on the same edge as `state_out`.
- Each state holds for exactly its `*_CYC` posedges, then transitions on the next edge. The dwell timer reloads on every state entry.
- One full approach cycle is ALLRED+RA+GREEN+AMBER cycles.
- Latency from `enable` rising (sampled) to RED: 1 clock.
- An `enable` change during a dwell takes effect only as specified above. No glitch states.

## Configuration
- `UK_LIGHT_PED_EN` defined:
  - Adds `ped_req` and `ped_walk`.
  - A `ped_req` high at any posedge sets a sticky pending flag.
  - On YELLOW exit with the flag set and `enable`=1, go to WALK for WALK_CYC cycles instead of RED, then RED.
  - The flag clears on WALK entry.
  - A request arriving during WALK is latched for the next YELLOW exit.
- `UK_LIGHT_PED_EN` undefined:
  - No pedestrian ports.
  - WALK is unreachable and bit 5 of `state_out` is constant 0.

## Structure
- Package `uk_light_pkg` holds the state enum typedef with one-hot encodings and the state width constant (6).
- Sub-module `uk_light_timer`: loadable down-counter with a `done` flag. It is sized by $clog2 of the maximum dwell parameter.
- The FSM and lamp decode live in `uk_light_junction`.

## Test plan
Configuration for all scenarios: N_WAY=3, ALLRED=2, RA=2, GREEN=5, AMBER=3.
- Reset held, `enable`=0 → `state_out`=000001, `red`=111, all other lamps 0, `active_way`=0.
- Raise `enable` → RED for 2 clk, RDYLW 2, GREEN 5 with `green`=001, YELLOW 3; then `active_way`=1 and RED again. Total of 12 clk per approach.
- Run 36 clk past the first RED → `active_way` sequence is 0,1,2,0 (wrap verified); `green` is never multi-hot.
- Drop `enable` in the 2nd GREEN cycle → YELLOW on the next edge, 3 clk of amber, then OFF with `red`=111. Re-enable → RED with `active_way` advanced.
- Assert `rst_n`=0 mid-GREEN, asynchronously → immediate OFF and `active_way`=0, without waiting for a clock edge.
- With `UK_LIGHT_PED_EN`: pulse `ped_req` during GREEN → after YELLOW, WALK for 6 clk with `ped_walk`=1 and `red`=111, then RED.
